// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle control FSM: states, opcodes, ALUOp and datapath selects.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECR,
      S_EXECI,
      S_ALUWB,
      S_BEQ,
      S_JAL,
      S_TRAP
   } state_t;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_A     = 2'b10;

   localparam logic [1:0] SRCB_WD   = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and ALU flag in, selects and enables out.
interface multicycle_controller_if;

   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;

   logic [1:0] ResultSrc;
   logic [2:0] ALUControl;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ImmSrc;
   logic       RegWrite;
   logic       AdrSrc;
   logic       IRWrite;
   logic       PCWrite;
   logic       MemWrite;
   logic       illegal;

   modport master (
      input  op, funct3, funct7b5, zero,
      output ResultSrc, ALUControl, ALUSrcA, ALUSrcB, ImmSrc,
             RegWrite, AdrSrc, IRWrite, PCWrite, MemWrite, illegal
   );

   modport slave (
      output op, funct3, funct7b5, zero,
      input  ResultSrc, ALUControl, ALUSrcA, ALUSrcB, ImmSrc,
             RegWrite, AdrSrc, IRWrite, PCWrite, MemWrite, illegal
   );

endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// alu_decoder: maps the FSM's ALUOp plus funct3/funct7 bits onto the ALU operation code.
module alu_decoder
   import riscv_ctrl_pkg::*;
(
   input  aluop_t     i_aluOp,
   input  logic [2:0] i_funct3,
   input  logic       i_opb5,
   input  logic       i_funct7b5,
   output logic [2:0] o_aluControl
);

   logic w_rtypeSub;

   // Only R-type (op[5]=1) with funct7b5 subtracts; addi must ignore imm bit 30.
   assign w_rtypeSub = i_opb5 & i_funct7b5;

   always_comb begin
      o_aluControl = ALU_ADD;
      case (i_aluOp)
         ALUOP_ADD: o_aluControl = ALU_ADD;
         ALUOP_SUB: o_aluControl = ALU_SUB;
         ALUOP_FUNCT: begin
            case (i_funct3)
               3'b000:  o_aluControl = w_rtypeSub ? ALU_SUB : ALU_ADD;
               3'b010:  o_aluControl = ALU_SLT;
               3'b110:  o_aluControl = ALU_OR;
               3'b111:  o_aluControl = ALU_AND;
               default: o_aluControl = ALU_ADD;
            endcase
         end
         default: o_aluControl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// RV32I multicycle main control FSM (lw, sw, R, I, beq, jal).
// Build option RV_CTRL_TRAP_EN: unknown opcodes lock into a TRAP state raising illegal.
module multicycle_controller
   import riscv_ctrl_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   multicycle_controller_if.master bus
);

   state_t     r_state;
   state_t     w_nextState;
   aluop_t     w_aluOp;
   logic [1:0] w_resultSrc;
   logic [1:0] w_srcA;
   logic [1:0] w_srcB;
   logic       w_adrSrc;
   logic       w_regWrite;
   logic       w_irWrite;
   logic       w_memWrite;
   logic       w_pcUpdate;
   logic       w_branch;
   logic [1:0] w_immSrc;
   logic [2:0] w_aluControl;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_FETCH;
      else      r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = S_FETCH;
      case (r_state)
         S_FETCH:  w_nextState = S_DECODE;
         S_DECODE: begin
            case (bus.op)
               OP_LW, OP_SW: w_nextState = S_MEMADR;
               OP_R:         w_nextState = S_EXECR;
               OP_I:         w_nextState = S_EXECI;
               OP_BEQ:       w_nextState = S_BEQ;
               OP_JAL:       w_nextState = S_JAL;
`ifdef RV_CTRL_TRAP_EN
               default:      w_nextState = S_TRAP;
`else
               default:      w_nextState = S_FETCH;
`endif
            endcase
         end
         S_MEMADR:   w_nextState = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  w_nextState = S_MEMWB;
         S_EXECR:    w_nextState = S_ALUWB;
         S_EXECI:    w_nextState = S_ALUWB;
         S_JAL:      w_nextState = S_ALUWB;
         S_TRAP:     w_nextState = S_TRAP;
         default:    w_nextState = S_FETCH;
      endcase
   end

   always_comb begin
      w_aluOp     = ALUOP_ADD;
      w_resultSrc = RES_ALUOUT;
      w_srcA      = SRCA_PC;
      w_srcB      = SRCB_WD;
      w_adrSrc    = 1'b0;
      w_regWrite  = 1'b0;
      w_irWrite   = 1'b0;
      w_memWrite  = 1'b0;
      w_pcUpdate  = 1'b0;
      w_branch    = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_srcB      = SRCB_FOUR;
            w_resultSrc = RES_ALURESULT;
            w_irWrite   = 1'b1;
            w_pcUpdate  = 1'b1;
         end
         S_DECODE: begin
            w_srcA = SRCA_OLDPC;
            w_srcB = SRCB_IMM;
         end
         S_MEMADR: begin
            w_srcA = SRCA_A;
            w_srcB = SRCB_IMM;
         end
         S_MEMREAD:  w_adrSrc = 1'b1;
         S_MEMWB: begin
            w_resultSrc = RES_DATA;
            w_regWrite  = 1'b1;
         end
         S_MEMWRITE: begin
            w_adrSrc   = 1'b1;
            w_memWrite = 1'b1;
         end
         S_EXECR: begin
            w_srcA  = SRCA_A;
            w_aluOp = ALUOP_FUNCT;
         end
         S_EXECI: begin
            w_srcA  = SRCA_A;
            w_srcB  = SRCB_IMM;
            w_aluOp = ALUOP_FUNCT;
         end
         S_ALUWB:    w_regWrite = 1'b1;
         S_BEQ: begin
            w_srcA   = SRCA_A;
            w_aluOp  = ALUOP_SUB;
            w_branch = 1'b1;
         end
         S_JAL: begin
            w_srcA     = SRCA_OLDPC;
            w_srcB     = SRCB_FOUR;
            w_pcUpdate = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      w_immSrc = IMM_I;
      case (bus.op)
         OP_SW:   w_immSrc = IMM_S;
         OP_BEQ:  w_immSrc = IMM_B;
         OP_JAL:  w_immSrc = IMM_J;
         default: w_immSrc = IMM_I;
      endcase
   end

   alu_decoder u_aluDecoder (
      .i_aluOp      (w_aluOp),
      .i_funct3     (bus.funct3),
      .i_opb5       (bus.op[5]),
      .i_funct7b5   (bus.funct7b5),
      .o_aluControl (w_aluControl)
   );

   // Enables are gated by rst so nothing writes while reset is held, even mid-instruction.
   assign bus.ResultSrc  = w_resultSrc;
   assign bus.ALUControl = w_aluControl;
   assign bus.ALUSrcA    = w_srcA;
   assign bus.ALUSrcB    = w_srcB;
   assign bus.ImmSrc     = w_immSrc;
   assign bus.AdrSrc     = w_adrSrc;
   assign bus.RegWrite   = rst & w_regWrite;
   assign bus.IRWrite    = rst & w_irWrite;
   assign bus.MemWrite   = rst & w_memWrite;
   assign bus.PCWrite    = rst & (w_pcUpdate | (w_branch & bus.zero));
`ifdef RV_CTRL_TRAP_EN
   assign bus.illegal    = rst & (r_state == S_TRAP);
`else
   assign bus.illegal    = 1'b0;
`endif

endmodule
